// File: rtl/sys_defs.sv
// Shared pipeline definitions.
//   ID_EX_PACKET : decoded instruction handed from decode to execute
//   SS_WIDTH     : superscalar issue width
//   ISSUE_CNT    : count of slots in an issue group (0..3)
package sys_defs;

  localparam int unsigned SS_WIDTH = 3;

  typedef logic [1:0] ISSUE_CNT;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [4:0]  dest_reg_idx;
    logic [4:0]  rs1_idx;
    logic [4:0]  rs2_idx;
    logic        valid;
  } ID_EX_PACKET;

endpackage

// File: rtl/issue_replay_ptr.sv
// Pointer bookkeeping for the issue replay buffer.
//   clock, reset : clock and async active-high reset
//   squash       : clear all pointers (highest priority)
//   enq_cnt      : entries written at tail this cycle (already gated by in_ready)
//   deq_cnt      : entries retired from head this cycle
//   head, tail   : oldest entry / next free entry, wrapping mod DEPTH
//   count        : occupied entries
//   in_ready     : room for a full group, from registered count only
module issue_replay_ptr
  import sys_defs::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       squash,
  input  ISSUE_CNT                   enq_cnt,
  input  ISSUE_CNT                   deq_cnt,
  output logic [$clog2(DEPTH)-1:0]   head,
  output logic [$clog2(DEPTH)-1:0]   tail,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       in_ready
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    head_d  = head_q + PW'(deq_cnt);
    tail_d  = tail_q + PW'(enq_cnt);
    count_d = count_q + CW'(enq_cnt) - CW'(deq_cnt);
    if (squash) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head     = head_q;
  assign tail     = tail_q;
  assign count    = count_q;
  // Ignores this cycle's consume so in_ready never depends on rollback.
  assign in_ready = (32'(count_q) + SS_WIDTH) <= DEPTH;

endmodule

// File: rtl/issue_replay_buffer.sv
// 3-wide in-order buffer between decode and hazard detection. Presents the
// oldest three entries as an issue group and retires only the slots the
// detection unit did not roll back.
//   clock, reset        : clock and async active-high reset
//   squash              : flush all entries
//   ex_stall            : group not consumed this cycle
//   in_count, in_packet : 0..3 decoded packets in program order
//   rollback            : youngest presented slots not issued
//   out_valid, out_packet : issue group, slot 0 oldest, thermometer valid
//   in_ready            : at least three free entries
// Optional: ISSUE_REPLAY_STATS_EN adds replay_cycles / replayed_insts counters.
module issue_replay_buffer
  import sys_defs::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        squash,
  input  logic        ex_stall,
  input  ISSUE_CNT    in_count,
  input  ID_EX_PACKET in_packet_0,
  input  ID_EX_PACKET in_packet_1,
  input  ID_EX_PACKET in_packet_2,
  input  ISSUE_CNT    rollback,
`ifdef ISSUE_REPLAY_STATS_EN
  output logic [31:0] replay_cycles,
  output logic [31:0] replayed_insts,
`endif
  output logic [2:0]  out_valid,
  output ID_EX_PACKET out_packet_0,
  output ID_EX_PACKET out_packet_1,
  output ID_EX_PACKET out_packet_2,
  output logic        in_ready
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;
  ISSUE_CNT      out_count, consumed, enq_cnt;
  ID_EX_PACKET   mem_q [DEPTH];
  ID_EX_PACKET   in_pkt [SS_WIDTH];
  ID_EX_PACKET   out_pkt [SS_WIDTH];

  assign in_pkt[0] = in_packet_0;
  assign in_pkt[1] = in_packet_1;
  assign in_pkt[2] = in_packet_2;

  always_comb begin
    out_count = (count >= CW'(SS_WIDTH)) ? ISSUE_CNT'(SS_WIDTH) : ISSUE_CNT'(count);
    consumed  = '0;
    if (!ex_stall && (rollback < out_count)) consumed = out_count - rollback;
    // Violating enqueues are dropped; squash discards everything this cycle.
    enq_cnt = (in_ready && !squash) ? in_count : '0;
  end

  issue_replay_ptr #(
    .DEPTH(DEPTH)
  ) u_ptr (
    .clock    (clock),
    .reset    (reset),
    .squash   (squash),
    .enq_cnt  (enq_cnt),
    .deq_cnt  (consumed),
    .head     (head),
    .tail     (tail),
    .count    (count),
    .in_ready (in_ready)
  );

  // Payload storage needs no reset: unoccupied slots are never presented.
  always_ff @(posedge clock) begin
    for (int i = 0; i < int'(SS_WIDTH); i++) begin
      if (i < int'(enq_cnt)) mem_q[tail + PW'(i)] <= in_pkt[i];
    end
  end

  always_comb begin
    for (int n = 0; n < int'(SS_WIDTH); n++) begin
      out_valid[n] = n < int'(out_count);
      out_pkt[n]   = out_valid[n] ? mem_q[head + PW'(n)] : '0;
    end
  end

  assign out_packet_0 = out_pkt[0];
  assign out_packet_1 = out_pkt[1];
  assign out_packet_2 = out_pkt[2];

  always_ff @(posedge clock) begin
    if (!reset) assert (in_count == '0 || in_ready);
  end

`ifdef ISSUE_REPLAY_STATS_EN
  logic        replay_hit;
  ISSUE_CNT    replay_n;
  logic [32:0] insts_sum;

  always_comb begin
    replay_hit = (out_count != '0) && !ex_stall && !squash && (rollback != '0);
    replay_n   = (rollback < out_count) ? rollback : out_count;
    insts_sum  = {1'b0, replayed_insts} + 33'(replay_n);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      replay_cycles  <= '0;
      replayed_insts <= '0;
    end else if (replay_hit) begin
      if (replay_cycles != '1) replay_cycles <= replay_cycles + 32'd1;
      replayed_insts <= insts_sum[32] ? '1 : insts_sum[31:0];
    end
  end
`endif

endmodule

// File: tb/tb_issue_replay_buffer.sv
module tb_issue_replay_buffer;
  import sys_defs::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        squash = 1'b0;
  logic        ex_stall = 1'b0;
  ISSUE_CNT    in_count = '0;
  ISSUE_CNT    rollback = '0;
  ID_EX_PACKET in_packet_0 = '0, in_packet_1 = '0, in_packet_2 = '0;
  logic [2:0]  out_valid;
  ID_EX_PACKET out_packet_0, out_packet_1, out_packet_2;
  logic        in_ready;
`ifdef ISSUE_REPLAY_STATS_EN
  logic [31:0] replay_cycles, replayed_insts;
`endif

  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  issue_replay_buffer #(
    .DEPTH(8)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .squash       (squash),
    .ex_stall     (ex_stall),
    .in_count     (in_count),
    .in_packet_0  (in_packet_0),
    .in_packet_1  (in_packet_1),
    .in_packet_2  (in_packet_2),
    .rollback     (rollback),
`ifdef ISSUE_REPLAY_STATS_EN
    .replay_cycles  (replay_cycles),
    .replayed_insts (replayed_insts),
`endif
    .out_valid    (out_valid),
    .out_packet_0 (out_packet_0),
    .out_packet_1 (out_packet_1),
    .out_packet_2 (out_packet_2),
    .in_ready     (in_ready)
  );

  function automatic ID_EX_PACKET addi(input int pc, input int rd, input int rs1, input int imm);
    ID_EX_PACKET p;
    logic [31:0] rdv, rsv, immv;
    rdv  = rd;
    rsv  = rs1;
    immv = imm;
    p = '0;
    p.pc           = pc;
    p.inst         = {immv[11:0], rsv[4:0], 3'b000, rdv[4:0], 7'b0010011};
    p.dest_reg_idx = rdv[4:0];
    p.rs1_idx      = rsv[4:0];
    p.valid        = 1'b1;
    return p;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input ISSUE_CNT n, input ID_EX_PACKET a, input ID_EX_PACKET b,
                       input ID_EX_PACKET c);
    in_count    = n;
    in_packet_0 = a;
    in_packet_1 = b;
    in_packet_2 = c;
  endtask

  task automatic idle();
    drive(2'd0, '0, '0, '0);
    rollback = '0;
    squash   = 1'b0;
    ex_stall = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    #1;
    total++;
    if (out_valid !== 3'b000) begin
      bad++; $display("FAIL reset_valid got=%b exp=000", out_valid);
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_ready got=%b exp=1", in_ready);
    end
    step();
    step();
    reset = 1'b0;
    step();
    total++;
    if ({out_packet_0, out_packet_1, out_packet_2} !== '0) begin
      bad++; $display("FAIL idle_packets got=%h exp=0", {out_packet_0, out_packet_1, out_packet_2});
    end
    total++;
    if (out_valid !== 3'b000 || in_ready !== 1'b1) begin
      bad++; $display("FAIL idle_state got=%b/%b exp=000/1", out_valid, in_ready);
    end
  endtask

  task automatic test_enqueue_drain();
    ID_EX_PACKET a1, a2, a3;
    a1 = addi(32'h100, 1, 0, 1);
    a2 = addi(32'h104, 2, 0, 2);
    a3 = addi(32'h108, 3, 0, 3);
    drive(2'd3, a1, a2, a3);
    step();
    drive(2'd0, '0, '0, '0);
    total++;
    if (out_valid !== 3'b111) begin
      bad++; $display("FAIL enq_valid got=%b exp=111", out_valid);
    end
    total++;
    if (out_packet_0 !== a1 || out_packet_1 !== a2 || out_packet_2 !== a3) begin
      bad++; $display("FAIL enq_order got=%h %h %h exp=%h %h %h",
                      out_packet_0, out_packet_1, out_packet_2, a1, a2, a3);
    end
    step();
    total++;
    if (out_valid !== 3'b000) begin
      bad++; $display("FAIL drain_valid got=%b exp=000", out_valid);
    end
  endtask

  task automatic test_rollback();
    ID_EX_PACKET g0, g1, g2;
    g0 = addi(32'h200, 1, 1, 1);
    g1 = addi(32'h204, 2, 1, 1);
    g2 = addi(32'h208, 3, 3, 3);
    drive(2'd3, g0, g1, g2);
    step();
    drive(2'd0, '0, '0, '0);
    rollback = 2'd2;
    step();
    rollback = 2'd0;
    total++;
    if (out_valid !== 3'b011) begin
      bad++; $display("FAIL rb2_valid got=%b exp=011", out_valid);
    end
    total++;
    if (out_packet_0 !== g1 || out_packet_1 !== g2 || out_packet_2 !== '0) begin
      bad++; $display("FAIL rb2_slots got=%h %h %h exp=%h %h 0",
                      out_packet_0, out_packet_1, out_packet_2, g1, g2);
    end
    step();
    total++;
    if (out_valid !== 3'b000) begin
      bad++; $display("FAIL rb2_drain got=%b exp=000", out_valid);
    end
    // rollback=3 stalls the whole group
    drive(2'd3, g0, g1, g2);
    step();
    drive(2'd0, '0, '0, '0);
    rollback = 2'd3;
    step();
    rollback = 2'd0;
    total++;
    if (out_valid !== 3'b111 || out_packet_0 !== g0 || out_packet_2 !== g2) begin
      bad++; $display("FAIL rb3_hold got=%b %h %h exp=111 %h %h",
                      out_valid, out_packet_0, out_packet_2, g0, g2);
    end
    step();
  endtask

  task automatic test_fill_wrap();
    ID_EX_PACKET p [6];
    ID_EX_PACKET w [3];
    for (int i = 0; i < 6; i++) p[i] = addi(32'h300 + 4 * i, i + 1, 0, i);
    ex_stall = 1'b1;
    drive(2'd3, p[0], p[1], p[2]);
    step();
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL fill3_ready got=%b exp=1", in_ready);
    end
    drive(2'd3, p[3], p[4], p[5]);
    step();
    drive(2'd0, '0, '0, '0);
    total++;
    if (in_ready !== 1'b0 || out_valid !== 3'b111 || out_packet_0 !== p[0]) begin
      bad++; $display("FAIL fill6 got=%b %b %h exp=0 111 %h", in_ready, out_valid, out_packet_0, p[0]);
    end
    step();
    total++;
    if (in_ready !== 1'b0 || out_packet_0 !== p[0]) begin
      bad++; $display("FAIL fill6_stall got=%b %h exp=0 %h", in_ready, out_packet_0, p[0]);
    end
    ex_stall = 1'b0;
    step();
    total++;
    if (in_ready !== 1'b1 || out_packet_0 !== p[3] || out_packet_2 !== p[5]) begin
      bad++; $display("FAIL drain_half got=%b %h %h exp=1 %h %h",
                      in_ready, out_packet_0, out_packet_2, p[3], p[5]);
    end
    step();
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 3; j++) w[j] = addi(32'h400 + 12 * k + 4 * j, 10 + j, k, j);
      drive(2'd3, w[0], w[1], w[2]);
      step();
      drive(2'd0, '0, '0, '0);
      total++;
      if (out_packet_0 !== w[0] || out_packet_1 !== w[1] || out_packet_2 !== w[2]) begin
        bad++; $display("FAIL wrap%0d got=%h %h %h exp=%h %h %h", k,
                        out_packet_0, out_packet_1, out_packet_2, w[0], w[1], w[2]);
      end
      step();
      total++;
      if (out_valid !== 3'b000) begin
        bad++; $display("FAIL wrap%0d_empty got=%b exp=000", k, out_valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    ID_EX_PACKET a0, a1, a2, b0, b1, b2;
    a0 = addi(32'h500, 5, 0, 1); a1 = addi(32'h504, 6, 0, 2); a2 = addi(32'h508, 7, 0, 3);
    b0 = addi(32'h50c, 8, 0, 4); b1 = addi(32'h510, 9, 0, 5); b2 = addi(32'h514, 10, 0, 6);
    drive(2'd3, a0, a1, a2);
    step();
    drive(2'd3, b0, b1, b2);
    step();
    drive(2'd0, '0, '0, '0);
    total++;
    if (out_valid !== 3'b111 || in_ready !== 1'b1 || out_packet_0 !== b0 || out_packet_2 !== b2) begin
      bad++; $display("FAIL b2b got=%b %b %h %h exp=111 1 %h %h",
                      out_valid, in_ready, out_packet_0, out_packet_2, b0, b2);
    end
    step();
    total++;
    if (out_valid !== 3'b000) begin
      bad++; $display("FAIL b2b_drain got=%b exp=000", out_valid);
    end
  endtask

  task automatic test_squash();
    ID_EX_PACKET s0;
    s0 = addi(32'h600, 1, 2, 3);
    drive(2'd3, s0, s0, s0);
    step();
    squash = 1'b1;
    step();
    squash = 1'b0;
    drive(2'd0, '0, '0, '0);
    total++;
    if (out_valid !== 3'b000 || in_ready !== 1'b1 || out_packet_0 !== '0) begin
      bad++; $display("FAIL squash got=%b %b %h exp=000 1 0", out_valid, in_ready, out_packet_0);
    end
    step();
    total++;
    if (out_valid !== 3'b000) begin
      bad++; $display("FAIL squash_after got=%b exp=000", out_valid);
    end
  endtask

  task automatic test_reset_mid();
    ID_EX_PACKET m0;
    m0 = addi(32'h700, 4, 4, 4);
    drive(2'd3, m0, m0, m0);
    step();
    drive(2'd0, '0, '0, '0);
    ex_stall = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    total++;
    if (out_valid !== 3'b000 || in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_mid got=%b %b exp=000 1", out_valid, in_ready);
    end
    step();
    reset = 1'b0;
    ex_stall = 1'b0;
    step();
    total++;
    if (out_valid !== 3'b000) begin
      bad++; $display("FAIL reset_mid_after got=%b exp=000", out_valid);
    end
  endtask

`ifdef ISSUE_REPLAY_STATS_EN
  task automatic test_stats();
    ID_EX_PACKET t0;
    t0 = addi(32'h800, 1, 1, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    drive(2'd3, t0, t0, t0);
    step();
    drive(2'd0, '0, '0, '0);
    rollback = 2'd1;
    for (int i = 0; i < 4; i++) step();
    rollback = 2'd0;
    total++;
    if (replay_cycles !== 32'd4 || replayed_insts !== 32'd4) begin
      bad++; $display("FAIL stats got=%0d %0d exp=4 4", replay_cycles, replayed_insts);
    end
    reset = 1'b1;
    #1;
    total++;
    if (replay_cycles !== 32'd0 || replayed_insts !== 32'd0) begin
      bad++; $display("FAIL stats_reset got=%0d %0d exp=0 0", replay_cycles, replayed_insts);
    end
    step();
    reset = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_enqueue_drain();
    test_rollback();
    test_fill_wrap();
    test_back_to_back();
    test_squash();
    test_reset_mid();
`ifdef ISSUE_REPLAY_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
